// File: rtl/online_op_sequencer_if.sv
// Digit-serial link between the sequencer and an online operator under test.
// Latency: none, plain wires. Backpressure: none, the operator consumes one digit per enable.
// master (sequencer): drives op_rst/op_en/op_x/op_y and samples op_z; slave (operator): the reverse.
interface online_op_sequencer_if #(
  parameter int C = 3
);
  logic         op_rst;
  logic         op_en;
  logic [C-1:0] op_x;
  logic [C-1:0] op_y;
  logic [C-1:0] op_z;

  modport master (output op_rst, output op_en, output op_x, output op_y, input op_z);
  modport slave  (input op_rst, input op_en, input op_x, input op_y, output op_z);
endinterface

// File: rtl/online_op_sequencer.sv
// Sequencer that streams two N-digit operands MSD-first into an online operator, captures N+1
// result digits, converts them to two's complement on the fly and checks the value.
// Latency: done pulses N+DELTA+3 cycles after start is sampled. Backpressure: none, start ignored while busy.
// Ports: clk/rst_n (async active-low), start, x_vec/y_vec/exp_val (latched per run),
//   op_if (master side of the operator link), busy/done/pass, z_vec/z_val (captured result).
// Optional macro ONLINE_SEQ_STATS_EN adds saturating run_cnt/fail_cnt outputs.
module online_op_sequencer #(
  parameter int N     = 6,
  parameter int C     = 3,
  parameter int RLOG  = 2,
  parameter int DELTA = 2,
  parameter int ACC_W = (N + 1) * RLOG + 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [N*C-1:0]          x_vec,
  input  logic [N*C-1:0]          y_vec,
  input  logic signed [ACC_W-1:0] exp_val,
  online_op_sequencer_if.master   op_if,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [(N+1)*C-1:0]      z_vec,
  output logic signed [ACC_W-1:0] z_val
`ifdef ONLINE_SEQ_STATS_EN
  ,
  output logic [15:0]             run_cnt,
  output logic [15:0]             fail_cnt
`endif
);

  localparam int KW = $clog2(N + DELTA);
  localparam logic [KW-1:0] K_LAST = KW'(N + DELTA - 1);
  localparam logic [KW-1:0] K_N    = KW'(N);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_CHECK, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q, k_d;
  logic [N*C-1:0]          x_lat_q, x_lat_d;
  logic [N*C-1:0]          y_lat_q, y_lat_d;
  logic signed [ACC_W-1:0] exp_lat_q, exp_lat_d;
  logic                    op_rst_q, op_rst_d;
  logic                    op_en_q, op_en_d;
  logic [C-1:0]            op_x_q, op_x_d;
  logic [C-1:0]            op_y_q, op_y_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    pass_q, pass_d;
  logic [(N+1)*C-1:0]      z_vec_q, z_vec_d;
  logic signed [ACC_W-1:0] z_val_q, z_val_d;
  logic [KW-1:0]           k_nxt;
`ifdef ONLINE_SEQ_STATS_EN
  logic [15:0]             run_cnt_q, run_cnt_d;
  logic [15:0]             fail_cnt_q, fail_cnt_d;
`endif

  // Digit idx of a latched operand (idx 0 = MSD); zero padding once the operand is exhausted.
  function automatic logic [C-1:0] digit_at(input logic [N*C-1:0] vec, input logic [KW-1:0] idx);
    logic [N*C-1:0] sh;
    digit_at = '0;
    if (idx < K_N) begin
      sh       = vec >> (C * (N - 1 - int'(idx)));
      digit_at = sh[C-1:0];
    end
  endfunction

  assign k_nxt = k_q + KW'(1);

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x_lat_d   = x_lat_q;
    y_lat_d   = y_lat_q;
    exp_lat_d = exp_lat_q;
    op_rst_d  = 1'b0;
    op_en_d   = op_en_q;
    op_x_d    = op_x_q;
    op_y_d    = op_y_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    z_vec_d   = z_vec_q;
    z_val_d   = z_val_q;
`ifdef ONLINE_SEQ_STATS_EN
    run_cnt_d  = run_cnt_q;
    fail_cnt_d = fail_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Outputs are registered, so the CLR-cycle values are set up on the edge entering CLR.
          state_d   = S_CLR;
          op_rst_d  = 1'b1;
          busy_d    = 1'b1;
          k_d       = '0;
          pass_d    = 1'b0;
          z_vec_d   = '0;
          z_val_d   = '0;
          x_lat_d   = x_vec;
          y_lat_d   = y_vec;
          exp_lat_d = exp_val;
        end
      end
      S_CLR: begin
        state_d = S_RUN;
        op_en_d = 1'b1;
        op_x_d  = digit_at(x_lat_q, '0);
        op_y_d  = digit_at(y_lat_q, '0);
      end
      S_RUN: begin
        // The first DELTA-1 output digits precede the MSD and carry no information.
        if (int'(k_q) >= DELTA - 1) begin
          z_vec_d = {z_vec_q[N*C-1:0], op_if.op_z};
          z_val_d = (z_val_q <<< RLOG) + {{(ACC_W-C){op_if.op_z[C-1]}}, op_if.op_z};
        end
        if (k_q == K_LAST) begin
          state_d = S_CHECK;
          op_en_d = 1'b0;
          op_x_d  = '0;
          op_y_d  = '0;
        end else begin
          k_d    = k_nxt;
          op_x_d = digit_at(x_lat_q, k_nxt);
          op_y_d = digit_at(y_lat_q, k_nxt);
        end
      end
      S_CHECK: begin
        state_d = S_DONE;
        pass_d  = (z_val_q == exp_lat_q);
        done_d  = 1'b1;
        busy_d  = 1'b0;
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef ONLINE_SEQ_STATS_EN
        if (run_cnt_q != 16'hFFFF) run_cnt_d = run_cnt_q + 16'd1;
        if (!pass_q && fail_cnt_q != 16'hFFFF) fail_cnt_d = fail_cnt_q + 16'd1;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      x_lat_q   <= '0;
      y_lat_q   <= '0;
      exp_lat_q <= '0;
      op_rst_q  <= 1'b0;
      op_en_q   <= 1'b0;
      op_x_q    <= '0;
      op_y_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      z_vec_q   <= '0;
      z_val_q   <= '0;
`ifdef ONLINE_SEQ_STATS_EN
      run_cnt_q  <= '0;
      fail_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      x_lat_q   <= x_lat_d;
      y_lat_q   <= y_lat_d;
      exp_lat_q <= exp_lat_d;
      op_rst_q  <= op_rst_d;
      op_en_q   <= op_en_d;
      op_x_q    <= op_x_d;
      op_y_q    <= op_y_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      z_vec_q   <= z_vec_d;
      z_val_q   <= z_val_d;
`ifdef ONLINE_SEQ_STATS_EN
      run_cnt_q  <= run_cnt_d;
      fail_cnt_q <= fail_cnt_d;
`endif
    end
  end

  assign op_if.op_rst = op_rst_q;
  assign op_if.op_en  = op_en_q;
  assign op_if.op_x   = op_x_q;
  assign op_if.op_y   = op_y_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign z_vec        = z_vec_q;
  assign z_val        = z_val_q;
`ifdef ONLINE_SEQ_STATS_EN
  assign run_cnt      = run_cnt_q;
  assign fail_cnt     = fail_cnt_q;
`endif

endmodule

// File: doc/online_op_sequencer.md
Name: online_op_sequencer

Overview:
- Parametrised digit-serial test sequencer for online (MSD-first) signed-digit operators, such as the radix-4 online adder.
- On `start` it resets the attached unit and streams two N-digit operands to it, most significant digit first, followed by DELTA zero digits.
- It captures N+1 output digits and converts them to a two's-complement value on the fly.
- It checks that value against the expected value. The check is by value, so any valid redundant digit vector passes.
- It sits between the board-level control (switches, buttons, 7-seg) and the operator under test.

Parameters:
- N, 6, number of operand digits.
- C, 3, bits per signed digit (two's complement).
- RLOG, 2, log2 of the radix (radix 4).
- DELTA, 2, online delay of the unit in enable cycles; must be at least 1.
- ACC_W, (N+1)*RLOG+2, width of the result and expected values.

Ports:
- clk, in, 1, clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, request a run; sampled only in IDLE.
- x_vec, in, N*C, operand x digits; digit 0 (MSD) is `x_vec[N*C-1 -: C]`.
- y_vec, in, N*C, operand y digits, same layout as x_vec.
- exp_val, in, ACC_W, signed expected result value.
- op_rst, out, 1, active-high synchronous reset to the unit.
- op_en, out, 1, enable to the unit.
- op_x, out, C, current x digit to the unit.
- op_y, out, C, current y digit to the unit.
- op_z, in, C, output digit from the unit.
- busy, out, 1, high from CLR through CHECK.
- done, out, 1, one-cycle pulse when a run completes.
- pass, out, 1, result of the last run; held until the next start.
- z_vec, out, (N+1)*C, captured digits, MSD in the top C bits.
- z_val, out, ACC_W, signed value of the captured digits.

Behaviour:
- Reset (`rst_n` low, asynchronous): state IDLE. Every output is 0: `op_rst`, `op_en`, `op_x`, `op_y`, `busy`, `done`, `pass`, `z_vec`, `z_val`. The cycle counter k is 0.
- States: IDLE -> CLR -> RUN -> CHECK -> DONE -> IDLE.
- IDLE:
  - `start`=1 at a clock edge: go to CLR.
  - `start` is ignored in every other state.
- CLR (1 cycle):
  - `op_rst`=1, `op_en`=0, `busy`=1.
  - Clear `z_vec`, `z_val`, `pass` and k.
  - Latch `x_vec`, `y_vec` and `exp_val` internally; later input changes do not affect the run.
- RUN (N+DELTA cycles, k = 0 .. N+DELTA-1):
  - `op_en`=1.
  - For k<N: `op_x` = latched x digit k, `op_y` = latched y digit k.
  - For k>=N: `op_x` = `op_y` = 0.
  - `op_z` during cycle k carries z digit j = k-DELTA+1, sampled at the edge ending cycle k.
  - Capture happens for k >= DELTA-1 only, which gives N+1 digits.
  - On each capture:
    - `z_vec` shifts left by C bits and takes `op_z` in the low digit.
    - `z_val` <= (`z_val` <<< RLOG) + sign_extend(`op_z`), full ACC_W width, no saturation.
- CHECK (1 cycle):
  - `op_en`=0, `op_x`=`op_y`=0.
  - `pass` <= (`z_val` == latched `exp_val`).
- DONE (1 cycle):
  - `done`=1, `busy`=0, then return to IDLE.
  - `z_vec`, `z_val` and `pass` hold until the next CLR.
- Latency: with `start` sampled at edge 0, `done` is high in cycle N+DELTA+3.
- Reset mid-run: the asynchronous return to IDLE drops `op_en`/`busy` immediately and discards the partial result.
- `start` held high: exactly one run, then another starts from IDLE. No lockout.
- Digit value -2^(C-1) is accepted and converted arithmetically; digit range is not checked.

Optional Feature:
- Macro: `ONLINE_SEQ_STATS_EN`.
- Defined:
  - Adds outputs `run_cnt[15:0]` and `fail_cnt[15:0]`, both 0 on reset.
  - `run_cnt` increments at each DONE.
  - `fail_cnt` increments at each DONE with `pass`=0.
  - Both saturate at 16'hFFFF.
- Not defined: the ports and counter logic are absent; all other behaviour is identical.

Test Plan (N=6, C=3, RLOG=2, DELTA=2, with a behavioural radix-4 online adder of delay 2):
- x=y=all digits 0, `exp_val`=0, pulse `start` -> `op_en` high for 8 cycles; `done` in cycle 11; `z_val`=0; `pass`=1.
- x=y=all digits +1 (value 1365 each), `exp_val`=2730 -> `z_val`=2730, `pass`=1; `z_vec` equals the unit's digit stream.
- x=y=all digits -3 (value -4095 each), `exp_val`=-8190 -> `z_val`=-8190, `pass`=1; no overflow at ACC_W=16.
- Same as the second case with `exp_val`=2731 -> `pass`=0; with STATS: `run_cnt` increments by 1, `fail_cnt` increments by 1.
- Pulse `start` again at RUN k=3 -> ignored: one CLR, eight `op_en` cycles, a single `done`.
- Drop `rst_n` at RUN k=4 -> `op_en`, `busy`, `z_val` and `pass` are 0 immediately. After release, a fresh run on the second-case vectors passes.
